// File: rtl/hs32_div.sv
// Iterative restoring radix-2 divider for the DIV/REM path of the execute stage.
// Resolves STEPS quotient bits per clock; divide-by-zero and signed overflow finish in one cycle.
module hs32_div #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  input  logic        i_rem,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_r,
  output logic [3:0]  o_fl
);

  if (STEPS != 1 && STEPS != 2) begin : g_bad_steps
    $error("hs32_div: STEPS must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvs_q;
  logic        sel_rem_q, neg_q_q, neg_r_q;

  logic        a_neg, b_neg, fast_div0, fast_ovf;
  logic [31:0] a_abs, b_abs, fast_res, q_fix, r_fix, res_calc;
  logic [32:0] trial;

  assign a_neg     = i_signed & i_a[31];
  assign b_neg     = i_signed & i_b[31];
  assign a_abs     = a_neg ? -i_a : i_a;
  assign b_abs     = b_neg ? -i_b : i_b;
  assign fast_div0 = (i_b == 32'd0);
  assign fast_ovf  = i_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign fast_res  = i_rem ? (fast_div0 ? i_a : 32'd0)
                           : (fast_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);

  // Partial remainder always stays below the divisor, so only the trial needs bit 32.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    trial  = '0;
    for (int k = 0; k < STEPS; k++) begin
      trial  = {rem_d, quot_d[31]};
      quot_d = {quot_d[30:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial     = trial - {1'b0, dvs_q};
        quot_d[0] = 1'b1;
      end
      rem_d = trial[31:0];
    end
  end

  assign cnt_d    = cnt_q + 6'(STEPS);
  assign q_fix    = neg_q_q ? -quot_d : quot_d;
  assign r_fix    = neg_r_q ? -rem_d : rem_d;
  assign res_calc = sel_rem_q ? r_fix : q_fix;

  function automatic logic [3:0] mk_fl(input logic [31:0] r, input logic c, input logic v);
    return {r[31], (r == 32'd0), c, v};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvs_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      o_valid   <= 1'b0;
      o_ready   <= 1'b1;
      o_r       <= '0;
      o_fl      <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid && o_ready) begin
          sel_rem_q <= i_rem;
          neg_q_q   <= a_neg ^ b_neg;
          neg_r_q   <= a_neg;
          o_ready   <= 1'b0;
          if (fast_div0 || fast_ovf) begin
            state_q <= DONE;
            o_valid <= 1'b1;
            o_r     <= fast_res;
            o_fl    <= mk_fl(fast_res, fast_div0, fast_ovf);
          end else begin
            state_q <= CALC;
            rem_q   <= '0;
            quot_q  <= a_abs;
            dvs_q   <= b_abs;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_d;
          if (cnt_d == 6'd32) begin
            state_q <= DONE;
            o_valid <= 1'b1;
            o_r     <= res_calc;
            o_fl    <= mk_fl(res_calc, 1'b0, 1'b0);
          end
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_div.sv
// Bench for hs32_div: STEPS=1 and STEPS=2 instances against an arithmetic reference,
// directed corner cases, backpressure, mid-operation reset and random traffic.
module tb_hs32_div;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       i_valid, o_ready, i_signed, i_rem, o_valid, i_ready;
  logic [1:0][31:0] i_a, i_b, o_r;
  logic [1:0][3:0]  o_fl;
  int n_cmp = 0, n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hs32_div #(.STEPS(g + 1)) u_dut (
      .clk(clk), .reset(reset), .i_valid(i_valid[g]), .o_ready(o_ready[g]),
      .i_a(i_a[g]), .i_b(i_b[g]), .i_signed(i_signed[g]), .i_rem(i_rem[g]),
      .o_valid(o_valid[g]), .i_ready(i_ready[g]), .o_r(o_r[g]), .o_fl(o_fl[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {nzcv, result} from plain integer arithmetic
  function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
    logic signed [31:0] sa, sb;
    logic [31:0] q, m, res;
    logic c, v;
    sa = a; sb = b; c = 1'b0; v = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; m = a; c = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; m = 32'd0; v = 1'b1;
    end else if (s) begin
      q = sa / sb; m = sa % sb;
    end else begin
      q = a / b; m = a % b;
    end
    res = r ? m : q;
    return {res[31], (res == 32'd0), c, v, res};
  endfunction

  task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r, input int stall);
    logic [35:0] e;
    int lat, exp_lat;
    string t;
    t = $sformatf("d%0d a=%h b=%h s=%0d r=%0d", d, a, b, s, r);
    e = ref_div(a, b, s, r);
    exp_lat = (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 32 / (d + 1) + 1;
    @(negedge clk);
    chk({t, " ready_idle"}, 32'(o_ready[d]), 32'd1);
    i_valid[d] = 1'b1; i_a[d] = a; i_b[d] = b; i_signed[d] = s; i_rem[d] = r;
    @(negedge clk);
    i_valid[d] = 1'b0; i_a[d] = $urandom; i_b[d] = $urandom;
    i_signed[d] = ~s; i_rem[d] = ~r;
    lat = 1;
    while (!o_valid[d] && lat < 100) begin
      if (lat == 3) i_valid[d] = 1'b1;
      @(negedge clk);
      lat++;
    end
    i_valid[d] = 1'b0;
    chk({t, " latency"}, 32'(lat), 32'(exp_lat));
    chk({t, " result"}, o_r[d], e[31:0]);
    chk({t, " flags"}, 32'(o_fl[d]), 32'(e[35:32]));
    chk({t, " ready_busy"}, 32'(o_ready[d]), 32'd0);
    for (int i = 0; i < stall; i++) begin
      i_valid[d] = 1'b1;
      @(negedge clk);
      chk({t, " hold_valid"}, 32'(o_valid[d]), 32'd1);
      chk({t, " hold_r"}, o_r[d], e[31:0]);
      chk({t, " hold_fl"}, 32'(o_fl[d]), 32'(e[35:32]));
      chk({t, " hold_ready"}, 32'(o_ready[d]), 32'd0);
    end
    i_valid[d] = 1'b0; i_ready[d] = 1'b1;
    @(negedge clk);
    i_ready[d] = 1'b0;
    chk({t, " done_valid"}, 32'(o_valid[d]), 32'd0);
    chk({t, " done_ready"}, 32'(o_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    logic seen;
    int d, mode;
    reset = 1'b1; i_valid = '0; i_ready = '0; i_a = '0; i_b = '0; i_signed = '0; i_rem = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d rst_valid", k), 32'(o_valid[k]), 32'd0);
      chk($sformatf("d%0d rst_ready", k), 32'(o_ready[k]), 32'd1);
      chk($sformatf("d%0d rst_r", k), o_r[k], 32'd0);
      chk($sformatf("d%0d rst_fl", k), 32'(o_fl[k]), 32'd0);
    end
    reset = 1'b0;

    for (int k = 0; k < 2; k++) begin
      do_op(k, 32'd100, 32'd7, 1'b0, 1'b0, 0);
      do_op(k, 32'd100, 32'd7, 1'b0, 1'b1, 0);
      do_op(k, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
      do_op(k, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
      do_op(k, 32'h1234, 32'd0, 1'b0, 1'b0, 0);
      do_op(k, 32'h1234, 32'd0, 1'b0, 1'b1, 0);
      do_op(k, 32'hFFFF_1234, 32'd0, 1'b1, 1'b1, 0);
      do_op(k, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
      do_op(k, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      do_op(k, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
      do_op(k, 32'd0, 32'd5, 1'b0, 1'b0, 0);
      do_op(k, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
      do_op(k, 32'd100, 32'd7, 1'b0, 1'b0, 5);
    end

    // Reset at CALC iteration 10 must discard the result
    @(negedge clk);
    i_valid[0] = 1'b1; i_a[0] = 32'd100; i_b[0] = 32'd7; i_signed[0] = 1'b0; i_rem[0] = 1'b0;
    i_ready[0] = 1'b1;
    @(negedge clk);
    i_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst valid", 32'(o_valid[0]), 32'd0);
    chk("midrst ready", 32'(o_ready[0]), 32'd1);
    chk("midrst r", o_r[0], 32'd0);
    chk("midrst fl", 32'(o_fl[0]), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid[0]) seen = 1'b1;
    end
    chk("midrst no_stale", 32'(seen), 32'd0);
    i_ready[0] = 1'b0;
    do_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, 1);
      mode = $urandom_range(0, 7);
      a = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: b = -($urandom_range(1, 16));
        4: b = a;
        default: b = $urandom;
      endcase
      do_op(d, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
